// File: rtl/rr_pkt_arb.sv
// Round-robin packet arbiter: merges REQ_NUM valid/ready packet streams onto a
// single registered output stream. The grant is held for the whole packet and
// the thermometer priority vector only moves at packet boundaries.
//
// Handshake: a beat moves on an interface in any cycle where valid and ready
// are both high. valid must not depend on ready. On the input side, ready is
// only offered to the granted source and only when the output register can load.
module rr_pkt_arb #(
  parameter int REQ_NUM    = 4,
  parameter int DATA_WIDTH = 8,
  localparam int SRC_W     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REQ_NUM-1:0]            in_valid,
  output logic [REQ_NUM-1:0]            in_ready,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] in_data,
  input  logic [REQ_NUM-1:0]            in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [SRC_W-1:0]              out_src,
  output logic [REQ_NUM-1:0]            prio_therm,
  output logic                          locked
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [SRC_W-1:0]        lock_src_q, lock_src_d;
  logic [REQ_NUM-1:0]      prio_d;

  logic                    ld;
  logic [REQ_NUM-1:0]      cand;
  logic [SRC_W-1:0]        win_idx;
  logic                    sel_en;
  logic [SRC_W-1:0]        sel_idx;
  logic [REQ_NUM-1:0]      gnt;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_last;
  logic                    xfer;

  // Output register can take a new beat when empty or draining this cycle.
  assign ld     = ~out_valid | out_ready;
  assign locked = (state_q == LOCK);

  // Round-robin pick: lowest eligible index, else lowest requesting index.
  always_comb begin
    cand    = in_valid & prio_therm;
    win_idx = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (in_valid[i]) win_idx = SRC_W'(i);
    end
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = SRC_W'(i);
    end
  end

  // Grant selection: the packet owner while locked, the arbitration winner otherwise.
  always_comb begin
    sel_en  = 1'b0;
    sel_idx = '0;
    if (state_q == LOCK) begin
      sel_en  = 1'b1;
      sel_idx = lock_src_q;
    end else if (|in_valid) begin
      sel_en  = 1'b1;
      sel_idx = win_idx;
    end
    for (int i = 0; i < REQ_NUM; i++) begin
      gnt[i] = sel_en && (sel_idx == SRC_W'(i));
    end
  end

  assign in_ready = gnt & {REQ_NUM{ld}};
  assign xfer     = |(in_valid & in_ready);

  // Beat mux driven by the one-hot grant.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (gnt[i]) begin
        sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last = in_last[i];
      end
    end
  end

  // Packet tracking and priority rotation at end-of-packet.
  always_comb begin
    state_d    = state_q;
    lock_src_d = lock_src_q;
    prio_d     = prio_therm;
    case (state_q)
      IDLE: begin
        if (xfer && !sel_last) begin
          state_d    = LOCK;
          lock_src_d = sel_idx;
        end
      end
      LOCK: begin
        if (xfer && sel_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (xfer && sel_last) begin
      for (int k = 0; k < REQ_NUM; k++) begin
        prio_d[k] = (k > int'(sel_idx));
      end
    end
  end

  // FSM, lock owner and priority registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_src_q <= '0;
      prio_therm <= '1;
    end else begin
      state_q    <= state_d;
      lock_src_q <= lock_src_d;
      prio_therm <= prio_d;
    end
  end

  // Output beat register; holds while stalled, empties when drained with no new beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (ld) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_src   <= sel_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_pkt_arb.sv
// Directed bench for rr_pkt_arb (REQ_NUM=4, DATA_WIDTH=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_rr_pkt_arb;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [1:0]      out_src;
  logic [N-1:0]    prio_therm;
  logic            locked;

  int checks = 0;
  int errors = 0;

  rr_pkt_arb #(.REQ_NUM(N), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_src    (out_src),
    .prio_therm (prio_therm),
    .locked     (locked)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [DW-1:0] d, input logic l);
    in_data[i*DW +: DW] = d;
    in_last[i] = l;
  endtask

  // Check the full registered output beat plus lock/priority state.
  task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d,
                         input logic l, input logic [1:0] s, input logic [N-1:0] p,
                         input logic lk);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".out_data"}, 32'(out_data), 32'(d));
    chk({tag, ".out_last"}, 32'(out_last), 32'(l));
    chk({tag, ".out_src"}, 32'(out_src), 32'(s));
    chk({tag, ".prio"}, 32'(prio_therm), 32'(p));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
  endtask

  task automatic chk_rdy(input string tag, input logic [N-1:0] exp);
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp));
  endtask

  logic [1:0]   rr_src  [5];
  logic [N-1:0] rr_prio [5];

  initial begin
    rr_src  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_prio = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b1110};

    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk_out("reset", 1'b0, 8'h00, 1'b0, 2'd0, 4'b1111, 1'b0);
    rst_n = 1'b1;

    // All four sources sending single-beat packets: strict rotation
    for (int i = 0; i < N; i++) set_src(i, DW'(8'h10 + i), 1'b1);
    in_valid = 4'b1111;
    chk_rdy("rr_first", 4'b0001);
    for (int b = 0; b < 5; b++) begin
      tick();
      chk_out($sformatf("rr_beat%0d", b), 1'b1, DW'(8'h10 + rr_src[b]), 1'b1,
              rr_src[b], rr_prio[b], 1'b0);
    end
    in_valid = '0;
    tick();
    chk_out("rr_idle", 1'b0, 8'h10, 1'b1, 2'd0, 4'b1110, 1'b0);

    // Move priority so source 2 wins next
    in_valid = 4'b0010;
    tick();
    chk_out("pre_lock", 1'b1, 8'h11, 1'b1, 2'd1, 4'b1100, 1'b0);

    // Source 2 sends a 3-beat packet while 0 and 1 keep requesting
    set_src(2, 8'hA0, 1'b0);
    in_valid = 4'b0111;
    chk_rdy("pkt_a0", 4'b0100);
    tick();
    chk_out("pkt_a0", 1'b1, 8'hA0, 1'b0, 2'd2, 4'b1100, 1'b1);
    set_src(2, 8'hA1, 1'b0);
    chk_rdy("pkt_a1", 4'b0100);
    tick();
    chk_out("pkt_a1", 1'b1, 8'hA1, 1'b0, 2'd2, 4'b1100, 1'b1);
    set_src(2, 8'hA2, 1'b1);
    chk_rdy("pkt_a2", 4'b0100);
    tick();
    chk_out("pkt_a2", 1'b1, 8'hA2, 1'b1, 2'd2, 4'b1000, 1'b0);
    // Source 3 now requesting: it is next in rotation ahead of 0 and 1
    in_valid = 4'b1011;
    chk_rdy("pkt_next", 4'b1000);
    tick();
    chk_out("pkt_next", 1'b1, 8'h13, 1'b1, 2'd3, 4'b0000, 1'b0);
    in_valid = '0;
    tick();
    chk("pkt_drain.out_valid", 32'(out_valid), 32'd0);

    // Backpressure: output held for 5 cycles, no loss or duplication
    set_src(0, 8'h20, 1'b1);
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    tick();
    chk_out("bp_load", 1'b1, 8'h20, 1'b1, 2'd0, 4'b1110, 1'b0);
    set_src(0, 8'h21, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk_rdy($sformatf("bp_hold%0d", c), 4'b0000);
      tick();
      chk_out($sformatf("bp_hold%0d", c), 1'b1, 8'h20, 1'b1, 2'd0, 4'b1110, 1'b0);
    end
    out_ready = 1'b1;
    chk_rdy("bp_release", 4'b0001);
    tick();
    chk_out("bp_release", 1'b1, 8'h21, 1'b1, 2'd0, 4'b1110, 1'b0);
    in_valid = '0;
    tick();
    chk("bp_drain.out_valid", 32'(out_valid), 32'd0);

    // Lock on source 1, owner goes quiet while source 0 requests
    set_src(0, 8'h22, 1'b1);
    set_src(1, 8'h30, 1'b0);
    in_valid = 4'b0011;
    tick();
    chk_out("gap_b0", 1'b1, 8'h30, 1'b0, 2'd1, 4'b1110, 1'b1);
    in_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      chk_rdy($sformatf("gap%0d", c), 4'b0010);
      tick();
      chk_out($sformatf("gap%0d", c), 1'b0, 8'h30, 1'b0, 2'd1, 4'b1110, 1'b1);
    end
    set_src(1, 8'h31, 1'b0);
    in_valid = 4'b0011;
    tick();
    chk_out("gap_b1", 1'b1, 8'h31, 1'b0, 2'd1, 4'b1110, 1'b1);
    set_src(1, 8'h32, 1'b1);
    tick();
    chk_out("gap_b2", 1'b1, 8'h32, 1'b1, 2'd1, 4'b1100, 1'b0);
    in_valid = '0;
    tick();
    chk("gap_drain.out_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a source-3 packet
    set_src(3, 8'h40, 1'b0);
    in_valid = 4'b1000;
    tick();
    chk_out("rst_b0", 1'b1, 8'h40, 1'b0, 2'd3, 4'b1100, 1'b1);
    rst_n = 1'b0;
    tick();
    chk_out("rst_mid", 1'b0, 8'h00, 1'b0, 2'd0, 4'b1111, 1'b0);
    rst_n = 1'b1;
    set_src(1, 8'h50, 1'b1);
    in_valid = 4'b0010;
    chk_rdy("rst_new", 4'b0010);
    tick();
    chk_out("rst_new", 1'b1, 8'h50, 1'b1, 2'd1, 4'b1100, 1'b0);

    // Single requester 3, back-to-back single-beat packets
    in_valid = 4'b1000;
    for (int b = 0; b < 3; b++) begin
      set_src(3, DW'(8'h60 + b), 1'b1);
      chk_rdy($sformatf("solo%0d", b), 4'b1000);
      tick();
      chk_out($sformatf("solo%0d", b), 1'b1, DW'(8'h60 + b), 1'b1, 2'd3, 4'b0000, 1'b0);
    end
    in_valid = '0;
    tick();
    chk("solo_drain.out_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
